// File: rtl/uc_ctrl.sv
// Control unit for the single-cycle microcontroller datapath: opcode decode,
// BOOT/RUN/HALT execution FSM with single-step, retired counter and illegal flag.
module uc_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             step_mode,
  input  logic             step,
  input  logic             resume,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic [2:0]       op,
  output logic             pc_en,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

  localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    boot_q, boot_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  logic       dec_inc, dec_inm, dec_we, dec_halt, dec_ill;
  logic [2:0] dec_op;
  logic       exec;
  logic       unused_opcode_hi;

  assign unused_opcode_hi = ^opcode[5:4];

  always_comb begin
    dec_inc  = 1'b1;
    dec_inm  = 1'b0;
    dec_we   = 1'b0;
    dec_op   = 3'b000;
    dec_halt = 1'b0;
    dec_ill  = 1'b0;
    if (!opcode[3]) begin
      dec_op = opcode[2:0];
      dec_we = 1'b1;
    end else begin
      case (opcode[2:0])
        3'b000: begin dec_we = 1'b1; dec_inm = 1'b1; end
        3'b001: dec_inc = 1'b0;
        3'b010: dec_inc = ~zero;
        3'b011: dec_inc = zero;
        3'b100: dec_halt = 1'b1;
        3'b101,
        3'b110: dec_ill = 1'b1;
        default: ;
      endcase
    end
  end

  assign exec = (state_q == S_RUN) && (!step_mode || step);

  always_comb begin
    state_d   = state_q;
    boot_d    = boot_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    pc_en     = 1'b0;
    we3       = 1'b0;
    s_inc     = dec_inc;
    s_inm     = dec_inm;
    op        = dec_op;
    case (state_q)
      S_BOOT: begin
        boot_d = boot_q + BW'(1);
        if (boot_q == BOOT_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (exec) begin
          retired_d = retired_q + CNT_W'(1);
          if (dec_ill) illegal_d = 1'b1;
          // HALT leaves the PC on its own word so resume can step past it
          if (dec_halt) begin
            state_d = S_HALT;
          end else begin
            pc_en = 1'b1;
            we3   = dec_we;
          end
        end
      end
      S_HALT: begin
        if (resume) begin
          pc_en   = 1'b1;
          s_inc   = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
    if (reset) begin
      state_d   = S_BOOT;
      boot_d    = '0;
      retired_d = '0;
      illegal_d = 1'b0;
      pc_en     = 1'b0;
      we3       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    boot_q    <= boot_d;
    retired_q <= retired_d;
    illegal_q <= illegal_d;
  end

  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_uc_ctrl.sv
// Directed scoreboard bench for uc_ctrl: each step queues expected outputs,
// then pops and compares them after the combinational outputs settle.
module tb_uc_ctrl;

  logic        clk = 1'b0;
  logic        reset, zero, step_mode, step, resume;
  logic [5:0]  opcode;
  logic        s_inc, s_inm, we3, pc_en, halted, illegal;
  logic [2:0]  op;
  logic [15:0] retired;

  typedef struct {
    string       tag;
    logic        pc_en, we3, s_inc, s_inm;
    logic [2:0]  op;
    logic        halted, illegal;
    logic [15:0] retired;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  logic [15:0] ret_exp = '0;

  uc_ctrl #(.CNT_W(16), .BOOT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .step_mode(step_mode), .step(step), .resume(resume),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .op(op), .pc_en(pc_en),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string field,
                     input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s.%s got %h expected %h", tag, field, got, exp);
    end
  endtask

  task automatic chk(input string tag, input logic rst, input logic [5:0] opc,
                     input logic z, input logic sm, input logic st, input logic rs,
                     input logic e_pc, input logic e_we, input logic e_inc,
                     input logic e_inm, input logic [2:0] e_op,
                     input logic e_halt, input logic e_ill, input bit counts);
    exp_t e;
    @(negedge clk);
    reset = rst; opcode = opc; zero = z; step_mode = sm; step = st; resume = rs;
    e.tag = tag; e.pc_en = e_pc; e.we3 = e_we; e.s_inc = e_inc; e.s_inm = e_inm;
    e.op = e_op; e.halted = e_halt; e.illegal = e_ill; e.retired = ret_exp;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    cmp(e.tag, "pc_en",   16'(pc_en),   16'(e.pc_en));
    cmp(e.tag, "we3",     16'(we3),     16'(e.we3));
    cmp(e.tag, "s_inc",   16'(s_inc),   16'(e.s_inc));
    cmp(e.tag, "s_inm",   16'(s_inm),   16'(e.s_inm));
    cmp(e.tag, "op",      16'(op),      16'(e.op));
    cmp(e.tag, "halted",  16'(halted),  16'(e.halted));
    cmp(e.tag, "illegal", 16'(illegal), 16'(e.illegal));
    cmp(e.tag, "retired", retired,      e.retired);
    if (counts) ret_exp = ret_exp + 16'd1;
  endtask

  initial begin
    int k;
    reset = 1'b1; opcode = 6'b001111; zero = 1'b0;
    step_mode = 1'b0; step = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);

    chk("rst",      1, 6'b000011, 0, 0, 0, 0,  0, 0, 1, 0, 3'b011, 0, 0, 0);
    chk("boot",     0, 6'b000011, 0, 0, 1, 1,  0, 0, 1, 0, 3'b011, 0, 0, 0);
    chk("alu",      0, 6'b000011, 0, 0, 0, 0,  1, 1, 1, 0, 3'b011, 0, 0, 1);
    chk("ldi",      0, 6'b001000, 0, 0, 0, 0,  1, 1, 1, 1, 3'b000, 0, 0, 1);
    chk("jmp",      0, 6'b001001, 0, 0, 0, 0,  1, 0, 0, 0, 3'b000, 0, 0, 1);
    chk("jz_z1",    0, 6'b001010, 1, 0, 0, 0,  1, 0, 0, 0, 3'b000, 0, 0, 1);
    chk("jz_z0",    0, 6'b001010, 0, 0, 0, 0,  1, 0, 1, 0, 3'b000, 0, 0, 1);
    chk("jnz_z1",   0, 6'b001011, 1, 0, 0, 0,  1, 0, 1, 0, 3'b000, 0, 0, 1);
    chk("jnz_z0",   0, 6'b001011, 0, 0, 0, 0,  1, 0, 0, 0, 3'b000, 0, 0, 1);
    chk("nop",      0, 6'b001111, 0, 0, 0, 0,  1, 0, 1, 0, 3'b000, 0, 0, 1);
    chk("ill_d",    0, 6'b001101, 0, 0, 0, 0,  1, 0, 1, 0, 3'b000, 0, 0, 1);
    chk("ill_e",    0, 6'b001110, 0, 0, 0, 0,  1, 0, 1, 0, 3'b000, 0, 1, 1);
    chk("halt",     0, 6'b001100, 0, 0, 0, 0,  0, 0, 1, 0, 3'b000, 0, 1, 1);
    for (int i = 0; i < 5; i++)
      chk("halt_hold", 0, 6'b001100, 0, 0, 1, 0, 0, 0, 1, 0, 3'b000, 1, 1, 0);
    chk("resume",   0, 6'b001100, 0, 0, 0, 1,  1, 0, 1, 0, 3'b000, 1, 1, 0);
    chk("post_res", 0, 6'b000001, 0, 0, 0, 0,  1, 1, 1, 0, 3'b001, 0, 1, 1);

    for (int i = 0; i < 2; i++)
      chk("sm_idle_a", 0, 6'b000010, 0, 1, 0, 0, 0, 0, 1, 0, 3'b010, 0, 1, 0);
    chk("sm_step_a", 0, 6'b000010, 0, 1, 1, 0, 1, 1, 1, 0, 3'b010, 0, 1, 1);
    for (int i = 0; i < 3; i++)
      chk("sm_idle_b", 0, 6'b000010, 0, 1, 0, 0, 0, 0, 1, 0, 3'b010, 0, 1, 0);
    chk("sm_step_b", 0, 6'b000010, 0, 1, 1, 0, 1, 1, 1, 0, 3'b010, 0, 1, 1);
    for (int i = 0; i < 2; i++)
      chk("sm_held", 0, 6'b000111, 0, 1, 1, 0, 1, 1, 1, 0, 3'b111, 0, 1, 1);
    chk("sm_hwait", 0, 6'b001100, 0, 1, 0, 0,  0, 0, 1, 0, 3'b000, 0, 1, 0);
    chk("sm_halt",  0, 6'b001100, 0, 1, 1, 0,  0, 0, 1, 0, 3'b000, 0, 1, 1);
    chk("res_step", 0, 6'b001100, 0, 1, 1, 1,  1, 0, 1, 0, 3'b000, 1, 1, 0);
    chk("sm_after", 0, 6'b000100, 0, 1, 0, 0,  0, 0, 1, 0, 3'b100, 0, 1, 0);

    // free-run NOPs to bring the counter up to the wrap point
    @(negedge clk);
    opcode = 6'b001111; step_mode = 1'b0; step = 1'b0; resume = 1'b0;
    k = 32'hFFFE - int'(ret_exp);
    repeat (k) @(posedge clk);
    ret_exp = 16'hFFFE;

    chk("wrap_a",   0, 6'b001111, 0, 0, 0, 0,  1, 0, 1, 0, 3'b000, 0, 1, 1);
    chk("wrap_b",   0, 6'b001111, 0, 0, 0, 0,  1, 0, 1, 0, 3'b000, 0, 1, 1);
    chk("wrap_c",   0, 6'b001111, 0, 0, 0, 0,  1, 0, 1, 0, 3'b000, 0, 1, 1);
    chk("mid_rst",  1, 6'b000011, 0, 0, 0, 0,  0, 0, 1, 0, 3'b011, 0, 1, 0);
    ret_exp = '0;
    chk("boot2",    0, 6'b000011, 0, 0, 0, 0,  0, 0, 1, 0, 3'b011, 0, 0, 0);
    chk("run2",     0, 6'b000011, 0, 0, 0, 0,  1, 1, 1, 0, 3'b011, 0, 0, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
